// File: rtl/mi3_pio_ctrl_if.sv
// mi3_pio_ctrl_if
//   Avalon-MM style register bus for the mi3 PIO slave.
//   address    : register word index (3 bits)
//   chipselect : slave select
//   write_n    : active-low write strobe, qualified by chipselect
//   read_n     : active-low read strobe, qualified by chipselect
//   writedata  : 32-bit write data
//   readdata   : 32-bit registered read data (slave -> master)
//   Modports: slave (the PIO), master (bus driver / testbench).
interface mi3_pio_ctrl_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic        read_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport slave (
        input  address, chipselect, write_n, read_n, writedata,
        output readdata
    );

    modport master (
        output address, chipselect, write_n, read_n, writedata,
        input  readdata
    );
endinterface

// File: rtl/mi3_pio_ctrl.sv
// mi3_pio_ctrl
//   Parametrised PIO slave: per-bit direction, atomic set/clear of the output
//   register, synchronised (optionally debounced) inputs, sticky edge capture
//   with write-1-to-clear, and a maskable level interrupt.
// Ports
//   clk      : system clock, rising edge
//   reset    : synchronous active-high reset
//   bus      : mi3_pio_ctrl_if.slave register bus (address/chipselect/
//              write_n/read_n/writedata in, readdata out, latency 1)
//   in_port  : asynchronous pin inputs (WIDTH)
//   out_port : output data register (WIDTH)
//   out_en   : per-bit output enable, mirrors DIR (WIDTH)
//   irq      : high while any (edge_capture & irq_mask) bit is set
// Register map: 0 DATA, 1 DIR, 2 MASK, 3 EDGE (W1C), 4 OUTSET, 5 OUTCLR, 6-7 zero.
// Build option: define PIO_DEBOUNCE_EN to insert a per-bit debounce filter
//   requiring DEBOUNCE_CYC stable cycles; otherwise the filter is a wire.
module mi3_pio_ctrl #(
    parameter int unsigned       WIDTH        = 8,
    parameter logic [WIDTH-1:0]  RESET_VALUE  = '0,
    parameter int unsigned       EDGE_TYPE    = 0,
    parameter int unsigned       DEBOUNCE_CYC = 16
) (
    input  logic             clk,
    input  logic             reset,
    mi3_pio_ctrl_if.slave    bus,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] out_en,
    output logic             irq
);

    logic [WIDTH-1:0] r_out_port;
    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_edge_cap;
    logic [31:0]      r_readdata;
    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_hist;

    logic             w_wr;
    logic             w_rd;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_filt;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_w1c;
    logic [31:0]      w_rdata;

    assign w_wr    = bus.chipselect & ~bus.write_n;
    assign w_rd    = bus.chipselect & ~bus.read_n;
    assign w_wdata = bus.writedata[WIDTH-1:0];
    assign w_w1c   = (w_wr && bus.address == 3'd3) ? w_wdata : '0;

    // Two-flop synchroniser and edge-history register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_hist  <= '0;
        end else begin
            r_sync1 <= in_port;
            r_sync2 <= r_sync1;
            r_hist  <= w_filt;
        end
    end

`ifdef PIO_DEBOUNCE_EN
    localparam int unsigned CW = $clog2(DEBOUNCE_CYC);

    logic [WIDTH-1:0] r_filt;
    logic [CW-1:0]    r_cnt [WIDTH];

    // A bit differing from the filter output can only hold one value, so
    // counting consecutive "differs" cycles is the stability count; a return
    // to the filtered value restarts it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_filt <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (r_sync2[i] == r_filt[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CW'(DEBOUNCE_CYC - 1)) begin
                    r_filt[i] <= r_sync2[i];
                    r_cnt[i]  <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end
            end
        end
    end

    assign w_filt = r_filt;
`else
    assign w_filt = r_sync2;
`endif

    always_comb begin
        w_edge = '0;
        if (EDGE_TYPE == 0) begin
            w_edge = w_filt & ~r_hist;
        end else if (EDGE_TYPE == 1) begin
            w_edge = ~w_filt & r_hist;
        end else begin
            w_edge = w_filt ^ r_hist;
        end
    end

    always_comb begin
        w_rdata = '0;
        case (bus.address)
            3'd0:    w_rdata[WIDTH-1:0] = w_filt;
            3'd1:    w_rdata[WIDTH-1:0] = r_dir;
            3'd2:    w_rdata[WIDTH-1:0] = r_mask;
            3'd3:    w_rdata[WIDTH-1:0] = r_edge_cap;
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_port <= RESET_VALUE;
            r_dir      <= '0;
            r_mask     <= '0;
            r_edge_cap <= '0;
            r_readdata <= '0;
        end else begin
            if (w_wr) begin
                case (bus.address)
                    3'd0:    r_out_port <= w_wdata;
                    3'd1:    r_dir      <= w_wdata;
                    3'd2:    r_mask     <= w_wdata;
                    3'd4:    r_out_port <= r_out_port | w_wdata;
                    3'd5:    r_out_port <= r_out_port & ~w_wdata;
                    default: ;
                endcase
            end
            // Set has priority over a simultaneous write-1-to-clear.
            r_edge_cap <= (r_edge_cap & ~w_w1c) | w_edge;
            if (w_rd) begin
                r_readdata <= w_rdata;
            end
        end
    end

    assign out_port    = r_out_port;
    assign out_en      = r_dir;
    assign irq         = |(r_edge_cap & r_mask);
    assign bus.readdata = r_readdata;

endmodule
